// File: rtl/mips_trace_buffer_if.sv
// Readout handshake for the MIPS writeback trace buffer.
// The buffer drives the head entry as master and the consumer returns rd_ready as slave.
interface mips_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_pc;
  logic [REG_AW-1:0] rd_reg;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  rd_stamp;

  modport master (
    output rd_valid, rd_pc, rd_reg, rd_data, rd_stamp,
    input  rd_ready
  );

  modport slave (
    input  rd_valid, rd_pc, rd_reg, rd_data, rd_stamp,
    output rd_ready
  );
endinterface

// File: rtl/mips_trace_buffer.sv
// Writeback trace capture for the MIPS core: records register writes into a circular
// buffer under three capture modes with a PC trigger, then drains it oldest first.
module mips_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8,
  parameter int CNT_W     = 32,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   trig_pc,
  input  logic [DATA_W-1:0]   pc_in,
  input  logic [DATA_W-1:0]   instr_in,
  input  logic                reg_write,
  input  logic [REG_AW-1:0]   write_reg,
  input  logic [DATA_W-1:0]   wb_data,
  mips_trace_buffer_if.master rd,
  output logic [CW-1:0]       count,
  output logic [CNT_W-1:0]    cycle_count,
  output logic [CNT_W-1:0]    wb_count,
  output logic                overflow,
  output logic [1:0]          state
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(POST_TRIG + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT  = CW'(DEPTH - 1);
  localparam logic [TW-1:0] POST_INIT = TW'(POST_TRIG);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            cur_state;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] trig_q;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [TW-1:0]     post_cnt;

  logic [DATA_W-1:0] mem_pc    [DEPTH];
  logic [REG_AW-1:0] mem_reg   [DEPTH];
  logic [DATA_W-1:0] mem_data  [DEPTH];
  logic [CNT_W-1:0]  mem_stamp [DEPTH];

  logic          capturing;
  logic          qual;
  logic          full;
  logic          record;
  logic          trig_hit;
  logic          pop;
  logic [TW-1:0] post_start;

  // A cycle with a zero instruction word is a pipeline bubble and never qualifies.
  assign capturing  = (cur_state == CAPTURE) || (cur_state == POST);
  assign qual       = capturing && reg_write && (write_reg != '0) && (instr_in != '0);
  assign full       = (count == FULL_CNT);
  assign record     = qual && !arm && !((mode_q == 2'd1) && full);
  assign trig_hit   = (cur_state == CAPTURE) && (pc_in == trig_q);
  assign pop        = rd.rd_valid && rd.rd_ready;
  assign post_start = record ? (POST_INIT - TW'(1)) : POST_INIT;

  assign state       = cur_state;
  assign rd.rd_valid = (cur_state == DONE) && (count != '0);
  assign rd.rd_pc    = rd.rd_valid ? mem_pc[head]    : '0;
  assign rd.rd_reg   = rd.rd_valid ? mem_reg[head]   : '0;
  assign rd.rd_data  = rd.rd_valid ? mem_data[head]  : '0;
  assign rd.rd_stamp = rd.rd_valid ? mem_stamp[head] : '0;

  // Storage carries no reset; the readout outputs are masked until an entry is valid.
  always_ff @(posedge clk) begin
    if (record) begin
      mem_pc[tail]    <= pc_in;
      mem_reg[tail]   <= write_reg;
      mem_data[tail]  <= wb_data;
      mem_stamp[tail] <= cycle_count;
    end
  end

  // Push and pop never coincide: pushes happen only while capturing, pops only in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_state   <= IDLE;
      mode_q      <= 2'd0;
      trig_q      <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      post_cnt    <= '0;
      cycle_count <= '0;
      wb_count    <= '0;
      overflow    <= 1'b0;
    end else if (arm) begin
      cur_state   <= CAPTURE;
      mode_q      <= (mode == 2'd3) ? 2'd0 : mode;
      trig_q      <= trig_pc;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      post_cnt    <= '0;
      cycle_count <= '0;
      wb_count    <= '0;
      overflow    <= 1'b0;
    end else begin
      if (capturing && (cycle_count != '1)) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
      if (qual && (wb_count != '1)) begin
        wb_count <= wb_count + CNT_W'(1);
      end

      if (record) begin
        tail <= tail + PW'(1);
        if (full) begin
          head     <= head + PW'(1);
          overflow <= 1'b1;
        end else begin
          count <= count + CW'(1);
        end
      end else if (pop) begin
        head  <= head + PW'(1);
        count <= count - CW'(1);
      end

      case (cur_state)
        CAPTURE: begin
          if (mode_q == 2'd1) begin
            if (record && (count == LAST_CNT)) cur_state <= DONE;
          end else if (mode_q == 2'd2) begin
            if (trig_hit) begin
              post_cnt  <= post_start;
              cur_state <= (post_start == '0) ? DONE : POST;
            end
          end else if (trig_hit) begin
            cur_state <= DONE;
          end
        end
        POST: begin
          if (record) begin
            post_cnt <= post_cnt - TW'(1);
            if (post_cnt == TW'(1)) cur_state <= DONE;
          end
        end
        default: cur_state <= cur_state;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Scoreboard bench for mips_trace_buffer: a queue model of the trace buffer predicts
// every recorded entry, and the readout port is drained against it.
module tb_mips_trace_buffer;

  localparam int DATA_W    = 32;
  localparam int REG_AW    = 5;
  localparam int DEPTH     = 16;
  localparam int POST_TRIG = 8;
  localparam int CNT_W     = 32;
  localparam int CW        = $clog2(DEPTH + 1);

  localparam int S_IDLE = 0, S_CAP = 1, S_POST = 2, S_DONE = 3;

  typedef struct {
    logic [DATA_W-1:0] pc;
    logic [REG_AW-1:0] rg;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  stamp;
  } entry_t;

  logic              clk;
  logic              reset_n;
  logic              arm;
  logic [1:0]        mode;
  logic [DATA_W-1:0] trig_pc;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] instr_in;
  logic              reg_write;
  logic [REG_AW-1:0] write_reg;
  logic [DATA_W-1:0] wb_data;
  logic [CW-1:0]     count;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  wb_count;
  logic              overflow;
  logic [1:0]        state;

  mips_trace_buffer_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) rd_if ();

  mips_trace_buffer #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .mode(mode), .trig_pc(trig_pc),
    .pc_in(pc_in), .instr_in(instr_in), .reg_write(reg_write), .write_reg(write_reg),
    .wb_data(wb_data), .rd(rd_if), .count(count), .cycle_count(cycle_count),
    .wb_count(wb_count), .overflow(overflow), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     tests_run;
  int     tests_failed;
  entry_t exp_q[$];
  int     m_state;
  int     m_mode;
  logic [DATA_W-1:0] m_trig;
  int     m_cycle;
  int     m_wb;
  int     m_ovf;
  int     m_post;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic modelClear();
    exp_q.delete();
    m_cycle = 0;
    m_wb    = 0;
    m_ovf   = 0;
    m_post  = 0;
  endtask

  // One clock of processor activity; the model advances at the same edge as the DUT.
  task automatic applyStimulus(input logic a, input logic [1:0] md, input logic [DATA_W-1:0] tpc,
                               input logic rw, input logic [REG_AW-1:0] wr,
                               input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] data);
    int     old_state;
    logic   cap, qual, rec;
    entry_t e;
    arm = a; mode = md; trig_pc = tpc;
    reg_write = rw; write_reg = wr; pc_in = pc; wb_data = data;
    instr_in = 32'h0100_0020 | pc;
    @(posedge clk);
    if (a) begin
      modelClear();
      m_state = S_CAP;
      m_mode  = (md == 2'd3) ? 0 : int'(md);
      m_trig  = tpc;
    end else begin
      old_state = m_state;
      cap  = (old_state == S_CAP) || (old_state == S_POST);
      qual = cap && rw && (wr != '0);
      rec  = qual && !(m_mode == 1 && exp_q.size() == DEPTH);
      e.pc = pc; e.rg = wr; e.data = data; e.stamp = CNT_W'(m_cycle);
      if (cap) m_cycle++;
      if (qual) m_wb++;
      if (rec) begin
        if (exp_q.size() == DEPTH) begin
          void'(exp_q.pop_front());
          m_ovf = 1;
        end
        exp_q.push_back(e);
      end
      if (old_state == S_CAP) begin
        if (m_mode == 1) begin
          if (exp_q.size() == DEPTH) m_state = S_DONE;
        end else if (pc == m_trig) begin
          if (m_mode == 2) begin
            m_post  = POST_TRIG - (rec ? 1 : 0);
            m_state = (m_post == 0) ? S_DONE : S_POST;
          end else begin
            m_state = S_DONE;
          end
        end
      end else if (old_state == S_POST && rec) begin
        m_post--;
        if (m_post == 0) m_state = S_DONE;
      end
    end
    #1;
    arm = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, ".state"}, state, m_state);
    checkOutput({tag, ".count"}, count, exp_q.size());
    checkOutput({tag, ".wb_count"}, wb_count, m_wb);
    checkOutput({tag, ".cycle_count"}, cycle_count, m_cycle);
    checkOutput({tag, ".overflow"}, overflow, m_ovf);
  endtask

  task automatic checkHead(input string tag);
    checkOutput({tag, ".rd_valid"}, rd_if.rd_valid, 1);
    checkOutput({tag, ".rd_pc"}, rd_if.rd_pc, exp_q[0].pc);
    checkOutput({tag, ".rd_reg"}, rd_if.rd_reg, exp_q[0].rg);
    checkOutput({tag, ".rd_data"}, rd_if.rd_data, exp_q[0].data);
    checkOutput({tag, ".rd_stamp"}, rd_if.rd_stamp, exp_q[0].stamp);
  endtask

  // Drain the buffer; the loop is bounded by the model's entry count.
  task automatic readAll(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkHead(tag);
      rd_if.rd_ready = 1'b1;
      @(posedge clk);
      void'(exp_q.pop_front());
      #1;
      rd_if.rd_ready = 1'b0;
      checkOutput({tag, ".count_pop"}, count, exp_q.size());
    end
    checkOutput({tag, ".rd_valid_empty"}, rd_if.rd_valid, 0);
    rd_if.rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rd_if.rd_ready = 1'b0;
    checkOutput({tag, ".count_empty_ready"}, count, 0);
    checkOutput({tag, ".state_empty"}, state, S_DONE);
  endtask

  function automatic logic [DATA_W-1:0] pcOf(input int base, input int i);
    return DATA_W'(base + 4 * i);
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    tests_run = 0; tests_failed = 0;
    reset_n = 1'b0; arm = 1'b0; mode = 2'd0; trig_pc = '0; pc_in = '0; instr_in = '0;
    reg_write = 1'b0; write_reg = '0; wb_data = '0; rd_if.rd_ready = 1'b0;
    m_state = S_IDLE; m_mode = 0; m_trig = '0;
    modelClear();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    checkStatus("reset");
    checkOutput("reset.rd_valid", rd_if.rd_valid, 0);

    // No capture happens without arm.
    for (int i = 0; i < 3; i++) applyStimulus(0, 2'd1, '0, 1, 5'd8, pcOf(32'h0040_0000, i), 32'd77 + i);
    checkStatus("idle");

    // Mode 1: fill once, stop at DEPTH entries.
    applyStimulus(1, 2'd1, 32'hFFFF_FFF0, 0, '0, '0, '0);
    checkStatus("m1_arm");
    for (int i = 1; i <= 20; i++)
      applyStimulus(0, 2'd0, '0, 1, REG_AW'(8 + (i % 4)), pcOf(32'h0040_0000, i), i);
    checkStatus("m1_done");
    checkOutput("m1.state_done", state, S_DONE);
    checkOutput("m1.wb_16", wb_count, 16);
    readAll("m1_read");

    // Mode 0: wrap with $zero writes and idle cycles, trigger on the 20th write.
    applyStimulus(1, 2'd0, pcOf(32'h0041_0000, 20), 0, '0, '0, '0);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(0, 2'd0, '0, 1, REG_AW'(8 + (i % 4)), pcOf(32'h0041_0000, i), i);
      if (i % 5 == 0 && i < 20) begin
        applyStimulus(0, 2'd0, '0, 1, 5'd0, pcOf(32'h0050_0000, i), 32'hDEAD_0000 + i);
        applyStimulus(0, 2'd0, '0, 0, 5'd9, pcOf(32'h0051_0000, i), 32'hBEEF_0000 + i);
      end
    end
    checkStatus("m0_done");
    checkOutput("m0.overflow", overflow, 1);
    checkOutput("m0.wb_20", wb_count, 20);
    for (int s = 0; s < 3; s++) begin
      checkHead("m0_stall");
      checkOutput("m0_stall.head_data", rd_if.rd_data, 5);
      @(posedge clk); #1;
    end
    readAll("m0_read");

    // Mode 2: trigger on the 6th write, POST_TRIG includes the trigger write.
    applyStimulus(1, 2'd2, pcOf(32'h0042_0000, 6), 0, '0, '0, '0);
    for (int i = 1; i <= 16; i++)
      applyStimulus(0, 2'd0, '0, 1, REG_AW'(16 + (i % 3)), pcOf(32'h0042_0000, i), i);
    checkStatus("m2_done");
    checkOutput("m2.count_13", count, 13);
    checkOutput("m2.last_wb", wb_count, 13);
    for (int i = 0; i < 3; i++) begin
      checkHead("m2_read");
      rd_if.rd_ready = 1'b1;
      @(posedge clk);
      void'(exp_q.pop_front());
      #1;
      rd_if.rd_ready = 1'b0;
    end
    checkOutput("m2.count_after3", count, 10);

    // arm mid-readout has priority and the same-cycle write is dropped.
    rd_if.rd_ready = 1'b1;
    applyStimulus(1, 2'd3, pcOf(32'h0043_0000, 50), 1, 5'd9, pcOf(32'h0043_0000, 0), 32'h1234);
    rd_if.rd_ready = 1'b0;
    checkStatus("arm_prio");
    checkOutput("arm_prio.state_cap", state, S_CAP);
    checkOutput("arm_prio.count0", count, 0);
    applyStimulus(0, 2'd0, '0, 1, 5'd10, pcOf(32'h0043_0000, 1), 32'h5678);
    applyStimulus(0, 2'd0, '0, 1, 5'd11, pcOf(32'h0043_0000, 50), 32'h9ABC);
    checkStatus("m3_done");
    readAll("m3_read");

    // Asynchronous reset in the middle of a capture.
    applyStimulus(1, 2'd0, 32'hFFFF_FFF0, 0, '0, '0, '0);
    applyStimulus(0, 2'd0, '0, 1, 5'd8, 32'h0044_0000, 32'h11);
    #2 reset_n = 1'b0;
    #1;
    m_state = S_IDLE;
    modelClear();
    checkStatus("async_reset");
    checkOutput("async_reset.rd_valid", rd_if.rd_valid, 0);
    checkOutput("async_reset.rd_data", rd_if.rd_data, 0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(0, 2'd0, '0, 1, 5'd8, 32'h0044_0004, 32'h22);
    checkStatus("post_reset_idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_trace_buffer.md
Name: mips_trace_buffer

Overview:
Synthesizable, parametrised writeback-trace capture block for the MIPS processor, replacing ad-hoc per-cycle simulation printing of PC/register writes.
- Snoops the processor's PC, instruction, reg_write, write_reg and ALU/writeback result every cycle.
- Records register-write events into a circular buffer, under one of three capture modes with a PC-match trigger.
- Exposes the frozen trace through a valid/ready readout port, plus cycle and writeback counters.
- Usable in the testbench and in silicon debug.

Parameters:
- DATA_W, 32, width of PC, instruction and writeback data.
- REG_AW, 5, register-address width.
- DEPTH, 16, trace entries (power of two, >=2).
- POST_TRIG, 8, entries captured after trigger in mode 2 (1..DEPTH).
- CNT_W, 32, width of cycle/writeback counters and entry timestamp.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- arm  in  1  single-cycle pulse: clear buffer/counters, start capture.
- mode  in  2  0=pre-trigger wrap, 1=fill-once, 2=post-trigger; 3 behaves as 0; sampled on arm.
- trig_pc  in  DATA_W  trigger PC; sampled on arm.
- pc_in  in  DATA_W  processor PC.
- instr_in  in  DATA_W  current instruction (not stored; nonzero qualifies a cycle).
- reg_write  in  1  processor writeback enable.
- write_reg  in  REG_AW  destination register.
- wb_data  in  DATA_W  value written.
- rd_ready  in  1  consumer accepts head entry.
- rd_valid  out  1  head entry valid.
- rd_pc  out  DATA_W  PC of head entry.
- rd_reg  out  REG_AW  register of head entry.
- rd_data  out  DATA_W  data of head entry.
- rd_stamp  out  CNT_W  cycle stamp of head entry.
- count  out  clog2(DEPTH+1)  entries held.
- cycle_count  out  CNT_W  cycles since arm while capturing.
- wb_count  out  CNT_W  qualifying writes seen (recorded or not).
- overflow  out  1  sticky: an unread entry was overwritten.
- state  out  2  0=IDLE, 1=CAPTURE, 2=POST, 3=DONE.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; pointers, count, cycle_count, wb_count, overflow = 0; rd_valid=0; rd_* outputs = 0.
- Qualifying write: reg_write=1 and write_reg!=0 while in CAPTURE or POST. Writes to $zero are never recorded or counted.
- Record: entry {pc_in, write_reg, wb_data, cycle_count} written at tail on the rising edge. Visible in count one cycle later.
- Capture latency is zero extra cycles beyond that register stage.
- Counters:
  - cycle_count increments every cycle in CAPTURE or POST; frozen in IDLE/DONE.
  - wb_count increments per qualifying write.
  - Both saturate at all-ones.
- arm has absolute priority in every state, including mid-capture and mid-readout. On arm, all of the following happen in that cycle, and no entry is recorded that cycle:
  - count, pointers, counters and overflow are cleared;
  - mode and trig_pc are latched;
  - state moves to CAPTURE.
- Trigger: pc_in==latched trig_pc while in CAPTURE. The write in the trigger cycle, if qualifying, is recorded.
- Mode 0: CAPTURE wraps; when full, a new entry overwrites the oldest, head advances, count stays DEPTH, overflow=1. Trigger -> DONE.
- Mode 1: trigger ignored. Writes recorded until count reaches DEPTH, then -> DONE. No overwrite; overflow stays 0.
- Mode 2:
  - CAPTURE wraps as in mode 0.
  - Trigger -> POST with post counter = POST_TRIG, minus 1 if the trigger cycle recorded a write. If that leaves 0, go directly to DONE.
  - POST records with wrap and decrements per recorded write; reaching 0 -> DONE.
- Readout:
  - rd_valid = (state==DONE && count!=0), driven combinationally from the head entry, oldest first.
  - rd_valid && rd_ready pops: head++, count-- on that edge.
  - rd_ready while rd_valid=0 has no effect.
  - In IDLE/CAPTURE/POST, rd_valid=0 and no pop occurs.
- DONE with count==0 stays DONE; only arm or reset leaves it. IDLE is left only by arm.
- Pointers wrap modulo DEPTH.

Test Plan:
- Reset/idle: reset_n low mid-run -> state=0, count=0, rd_valid=0. No capture without arm even with reg_write=1, write_reg=8.
- Mode 1 fill: arm, 20 writes to $t0..$t3 with values 1..20 -> DONE after 16th write. Readout gives data 1..16 oldest first, count decrements to 0, overflow=0, wb_count=16.
- Mode 0 wrap + trigger: DEPTH=16, 20 writes data 1..20, trigger at PC of the 20th write -> DONE. Readout gives 5..20, overflow=1.
- Mode 2 post-trigger: 5 writes, trigger with write (data 6), then 10 more writes -> DONE after data 13. Entries 1..13 read out (POST_TRIG=8 incl. trigger write).
- $zero filter and stamps: write_reg=0 writes are not recorded and wb_count is unchanged. rd_stamp equals cycle_count value at capture. Stall rd_ready=0 for 3 cycles -> rd_valid stays 1, same entry held.
- arm priority: arm asserted during readout with reg_write=1 -> count=0, counters 0, state=CAPTURE, that cycle's write not recorded.
